// File: rtl/wb_stage_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_gen
// Description : Parametrised MIPS write-back stage. Commits GPR writes,
//               CP0 writes, exceptions and eret; supports multi-cycle CP0
//               reads for mfc0, a forwarding entry, debug trace and a
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_gen #(
    parameter int XLEN       = 32,
    parameter int RF_AW      = 5,
    parameter int CP0_AW     = 5,
    parameter int CP0_RD_LAT = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // MEM -> WB handshake and payload
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [XLEN-1:0]   ms_pc,
    input  logic              ms_gr_we,
    input  logic [RF_AW-1:0]  ms_dest,
    input  logic [XLEN-1:0]   ms_result,
    input  logic              ms_res_from_cp0,
    input  logic              ms_mtc0_we,
    input  logic [CP0_AW-1:0] ms_cp0_addr,
    input  logic [XLEN-1:0]   ms_rt_value,
    input  logic              ms_eret,
    input  logic              ms_bd,
    input  logic              ms_ex,
    input  logic [4:0]        ms_excode,
    input  logic [XLEN-1:0]   ms_badvaddr,
    input  logic              ms_inst_addr_ex,
    // CP0 interface
    output logic [CP0_AW-1:0] cp0_raddr,
    input  logic [XLEN-1:0]   cp0_rdata,
    output logic              cp0_ex,
    output logic [4:0]        cp0_excode,
    output logic [XLEN-1:0]   cp0_badvaddr,
    output logic              cp0_bd,
    output logic [XLEN-1:0]   cp0_epc_pc,
    output logic              cp0_mtc0_we,
    output logic [CP0_AW-1:0] cp0_waddr,
    output logic [XLEN-1:0]   cp0_wdata,
    output logic              cp0_eret,
    output logic              ws_flush,
    // Register file and forwarding
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              ws_fwd_valid,
    output logic [RF_AW-1:0]  ws_fwd_dest,
    output logic [XLEN-1:0]   ws_fwd_data,
    output logic              ws_fwd_busy,
    // Statistics and trace
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [XLEN-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [RF_AW-1:0]  debug_wb_rf_wnum,
    output logic [XLEN-1:0]   debug_wb_rf_wdata
);

    // Held instruction
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic              r_gr_we;
    logic [RF_AW-1:0]  r_dest;
    logic [XLEN-1:0]   r_result;
    logic              r_res_cp0;
    logic              r_mtc0_we;
    logic [CP0_AW-1:0] r_cp0_addr;
    logic [XLEN-1:0]   r_rt_value;
    logic              r_eret;
    logic              r_bd;
    logic              r_ex;
    logic [4:0]        r_excode;
    logic [XLEN-1:0]   r_badvaddr;
    logic              r_inst_addr_ex;
    logic [CNT_W-1:0]  r_retired;

    logic              w_ready_go;
    logic              w_allowin;
    logic              w_capture;
    logic              w_commit;
    logic              w_flush;
    logic              w_rf_we;
    logic [XLEN-1:0]   w_cp0_data;
    logic [XLEN-1:0]   w_rf_wdata;

    assign w_allowin = !r_valid || w_ready_go;
    assign w_capture = ms_to_ws_valid && w_allowin;
    assign w_commit  = r_valid && w_ready_go;
    assign w_flush   = w_commit && (r_ex || r_eret);
    assign w_rf_we   = w_commit && r_gr_we && !r_ex;
    assign w_rf_wdata = r_res_cp0 ? w_cp0_data : r_result;

    if (CP0_RD_LAT == 0) begin : g_lat_comb
        // CP0 read data is combinational: no wait state, no latch.
        assign w_ready_go = 1'b1;
        assign w_cp0_data = cp0_rdata;
    end else begin : g_lat_wait
        localparam logic [1:0] c_LAT = 2'(CP0_RD_LAT);

        logic [1:0]      r_wait_cnt;
        logic [XLEN-1:0] r_cp0_data;
        logic            w_waiting;

        assign w_waiting  = r_valid && r_res_cp0 && (r_wait_cnt != c_LAT);
        assign w_ready_go = !w_waiting;
        assign w_cp0_data = r_cp0_data;

        // Count wait cycles of an mfc0; latch CP0 data on the edge where
        // the count reaches the read latency.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_wait_cnt <= 2'd0;
                r_cp0_data <= '0;
            end else if (w_capture) begin
                r_wait_cnt <= 2'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
                if (r_wait_cnt == c_LAT - 2'd1) begin
                    r_cp0_data <= cp0_rdata;
                end
            end
        end
    end

    // Stage valid: a flush drops whatever MEM presents in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_valid <= 1'b0;
        end else if (w_allowin) begin
            r_valid <= ms_to_ws_valid;
        end
    end

    // Payload registers; qualified by r_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_pc           <= ms_pc;
            r_gr_we        <= ms_gr_we;
            r_dest         <= ms_dest;
            r_result       <= ms_result;
            r_res_cp0      <= ms_res_from_cp0;
            r_mtc0_we      <= ms_mtc0_we;
            r_cp0_addr     <= ms_cp0_addr;
            r_rt_value     <= ms_rt_value;
            r_eret         <= ms_eret;
            r_bd           <= ms_bd;
            r_ex           <= ms_ex;
            r_excode       <= ms_excode;
            r_badvaddr     <= ms_badvaddr;
            r_inst_addr_ex <= ms_inst_addr_ex;
        end
    end

    // Retired-instruction counter: every non-excepting commit, wraps freely.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_retired <= '0;
        end else if (w_commit && !r_ex) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign ws_allowin   = w_allowin;

    assign cp0_raddr    = r_cp0_addr;
    assign cp0_ex       = w_commit && r_ex;
    assign cp0_excode   = r_excode;
    assign cp0_badvaddr = r_inst_addr_ex ? r_pc : r_badvaddr;
    assign cp0_bd       = r_bd;
    assign cp0_epc_pc   = r_pc;
    assign cp0_mtc0_we  = w_commit && r_mtc0_we && !r_ex;
    assign cp0_waddr    = r_cp0_addr;
    assign cp0_wdata    = r_rt_value;
    assign cp0_eret     = w_commit && r_eret && !r_ex;
    assign ws_flush     = w_flush;

    assign rf_we        = w_rf_we;
    assign rf_waddr     = r_dest;
    assign rf_wdata     = w_rf_wdata;
    assign ws_fwd_valid = r_valid && r_gr_we && !r_ex;
    assign ws_fwd_dest  = r_dest;
    assign ws_fwd_data  = w_rf_wdata;
    assign ws_fwd_busy  = r_valid && r_res_cp0 && !w_ready_go;

    assign retired_cnt       = r_retired;
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule
`default_nettype wire

// File: doc/wb_stage_gen.md
Name: wb_stage_gen

Overview:
Parametrised write-back stage for the 5-stage MIPS pipeline; replaces the fixed 32-bit, single-cycle WB stage. Accepts one instruction per cycle from MEM. Supports a multi-cycle CP0 read (for mfc0), exception/eret flush signalling, register-file write-back with a forwarding path, and debug trace. Adds a retired-instruction counter.

Parameters:
XLEN, 32, datapath width (result, pc, rt value, badvaddr, CP0 data)
RF_AW, 5, register-file address width
CP0_AW, 5, CP0 register address width
CP0_RD_LAT, 1, CP0 read latency in cycles (0..3); 0 means cp0_rdata is combinational
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
ms_to_ws_valid  in  1  MEM holds a valid instruction
ws_allowin  out  1  WB can accept this cycle
ms_pc  in  XLEN  instruction pc
ms_gr_we  in  1  GPR write enable
ms_dest  in  RF_AW  GPR destination
ms_result  in  XLEN  result computed in MEM
ms_res_from_cp0  in  1  mfc0: result comes from CP0
ms_mtc0_we  in  1  mtc0 write
ms_cp0_addr  in  CP0_AW  CP0 register address
ms_rt_value  in  XLEN  mtc0 source data
ms_eret  in  1  eret instruction
ms_bd  in  1  instruction sits in a delay slot
ms_ex  in  1  exception raised upstream
ms_excode  in  5  exception code
ms_badvaddr  in  XLEN  faulting data address
ms_inst_addr_ex  in  1  fetch-address exception
cp0_raddr  out  CP0_AW  CP0 read address
cp0_rdata  in  XLEN  CP0 read data
cp0_ex  out  1  exception commit pulse
cp0_excode  out  5  exception code
cp0_badvaddr  out  XLEN  bad address to CP0
cp0_bd  out  1  delay-slot flag
cp0_epc_pc  out  XLEN  pc of the faulting instruction
cp0_mtc0_we  out  1  CP0 write enable
cp0_waddr  out  CP0_AW  CP0 write address
cp0_wdata  out  XLEN  CP0 write data
cp0_eret  out  1  eret commit pulse
ws_flush  out  1  pipeline flush (cp0_ex or cp0_eret)
rf_we  out  1  GPR write enable
rf_waddr  out  RF_AW  GPR write address
rf_wdata  out  XLEN  GPR write data
ws_fwd_valid  out  1  forwarding entry valid
ws_fwd_dest  out  RF_AW  forwarding destination
ws_fwd_data  out  XLEN  forwarding data (equals rf_wdata)
ws_fwd_busy  out  1  valid mfc0 not yet complete; consumers must stall
retired_cnt  out  CNT_W  retired-instruction count
debug_wb_pc  out  XLEN  trace pc
debug_wb_rf_wen  out  4  {4{rf_we}}
debug_wb_rf_wnum  out  RF_AW  trace destination
debug_wb_rf_wdata  out  XLEN  trace data

Behaviour:
- Reset (resetn=0 at posedge): ws_valid=0, wait counter=0, retired_cnt=0, latched CP0 data=0. While ws_valid=0, every enable/pulse output is 0.
- Capture: all ms_* fields are registered when ms_to_ws_valid && ws_allowin. ws_allowin = !ws_valid || ws_ready_go.
- ws_ready_go = 1 unless ws_valid && res_from_cp0 && CP0_RD_LAT>0. In that case a counter starts at 0 on entry and increments each cycle; ready_go=1 when counter==CP0_RD_LAT.
- When the counter reaches CP0_RD_LAT, cp0_rdata is latched on that edge. cp0_raddr = registered cp0_addr and is held stable for the whole wait.
- ws_fwd_busy = ws_valid && res_from_cp0 && !ready_go.
- Commit cycle = ws_valid && ws_ready_go.
- cp0_ex = commit && ex. cp0_eret = commit && eret && !ex. ws_flush = cp0_ex || cp0_eret.
- cp0_badvaddr = inst_addr_ex ? pc : badvaddr.
- cp0_mtc0_we = commit && mtc0_we && !ex.
- rf_we = commit && gr_we && !ex.
- rf_wdata = res_from_cp0 ? CP0 data : result. CP0 data is the latched value, or cp0_rdata directly when LAT=0.
- The forwarding entry is valid whenever ws_valid && gr_we && !ex, including the busy cycles.
- Flush: the cycle after ws_flush, ws_valid=0 regardless of ms_to_ws_valid (flush wins). The instruction presented that cycle is dropped, so flush pulses last exactly one cycle.
- retired_cnt increments by 1 on each commit with !ex, eret included. It wraps modulo 2^CNT_W without saturating.
- Reset mid-wait aborts the mfc0: no rf write and no count.
- Debug outputs mirror pc, rf_we, dest and rf_wdata.

Test Plan:
- Back-to-back ALU ops (CP0_RD_LAT=1): addu to r3 with result 0x1234 at pc 0xBFC00010 -> rf_we=1 and rf_wdata=0x1234 one cycle after capture; ws_allowin stays 1; retired_cnt increments once per op.
- mfc0 with CP0_RD_LAT=2 and cp0_rdata=0xDEADBEEF: ws_allowin=0 for 2 cycles and ws_fwd_busy=1; rf_we=1 with 0xDEADBEEF on the 3rd cycle.
- Exception (excode=0x04, badvaddr=0x80000003) with gr_we=1 and a valid follower: cp0_ex is a 1-cycle pulse and rf_we=0. The follower is dropped and ws_valid=0 the next cycle.
- Fetch-address exception at pc 0xBFC00101 -> cp0_badvaddr=0xBFC00101.
- eret and mtc0: mtc0 (addr 12, data 0x1) -> cp0_mtc0_we=1 for 1 cycle. eret -> cp0_eret=1 and ws_flush=1 for 1 cycle, and retired_cnt increments.
- CNT_W=4: 17 commits -> retired_cnt=1 (wrap). Pulling resetn=0 mid mfc0 wait -> no rf_we, counter and valid cleared.
